state_timer_bank: RTL and testbench

Bank of independent countdown timers that pace the HD44780 controller's state machine: power-on waits, enable-pulse widths, and command/data settle delays. Each channel loads a count, counts prescaled ticks, and emits a one-cycle `end_strobe` that tells the caller to advance state. This generation adds channel count, counter width, a per-channel clock prescaler, periodic (auto-reload) mode, abort, and busy status. The block sits between `hd44780_top`'s clock and the LCD sequencing logic.

---
 rtl/state_timer_bank_if.sv | 35 +++
 rtl/state_timer_bank.sv | 114 +++++++++++
 tb/tb_state_timer_bank.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/state_timer_bank_if.sv
// -----------------------------------------------------------------------------
// state_timer_bank_if
// Control/status bundle of the HD44780 pacing timer bank.
//   DAT_I        load value in ticks, sampled with start_strobe
//   SEL_I        target channel for start_strobe / abort_strobe
//   periodic_i   1 = auto-reload, captured with start_strobe
//   start_strobe load and start the selected channel
//   abort_strobe stop the selected channel without a strobe
//   end_strobe   one-cycle expiry pulse, one bit per channel
//   busy         channel is counting, one bit per channel
// master: sequencing logic driving the timers; slave: the timer bank.
// -----------------------------------------------------------------------------
interface state_timer_bank_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int SEL_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [WIDTH-1:0]    DAT_I;
  logic [SEL_BITS-1:0] SEL_I;
  logic                periodic_i;
  logic                start_strobe;
  logic                abort_strobe;
  logic [CHANNELS-1:0] end_strobe;
  logic [CHANNELS-1:0] busy;

  modport master (
    output DAT_I, SEL_I, periodic_i, start_strobe, abort_strobe,
    input  end_strobe, busy
  );

  modport slave (
    input  DAT_I, SEL_I, periodic_i, start_strobe, abort_strobe,
    output end_strobe, busy
  );
endinterface

// File: rtl/state_timer_bank.sv
// -----------------------------------------------------------------------------
// state_timer_bank
// Bank of independent prescaled countdown timers that pace the HD44780
// sequencer (power-on waits, enable pulse widths, settle delays).
// Ports:
//   CLK_I    single clock, rising edge
//   RST_N_I  asynchronous active-low reset (deassertion synchronised upstream)
//   bus      state_timer_bank_if.slave: DAT_I, SEL_I, periodic_i,
//            start_strobe, abort_strobe in; end_strobe, busy out (registered)
// A channel started with N > 0 strobes N*PRESCALE_DIV edges after the start
// edge; N = 0 strobes one edge after the start edge without going busy.
// -----------------------------------------------------------------------------
module state_timer_bank #(
  parameter int WIDTH        = 16,
  parameter int CHANNELS     = 2,
  parameter int PRESCALE_DIV = 48,
  parameter int SEL_BITS     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              CLK_I,
  input  logic              RST_N_I,
  state_timer_bank_if.slave bus
);

  localparam int            PW         = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE_DIV - 1);

  logic [CHANNELS-1:0] w_busy;
  logic [CHANNELS-1:0] w_end;

  assign bus.busy       = w_busy;
  assign bus.end_strobe = w_end;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam logic [SEL_BITS-1:0] CH_ID = SEL_BITS'(g);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic [PW-1:0]    r_presc;
    logic             r_periodic;
    logic             r_busy;
    logic             r_end;
    // Zero-length start: strobe is deferred one edge so it lands at E0+1.
    logic             r_zero;
    logic             w_start;
    logic             w_abort;

    // SEL_I values >= CHANNELS match no CH_ID and are therefore ignored.
    assign w_start = bus.start_strobe && (bus.SEL_I == CH_ID);
    assign w_abort = bus.abort_strobe && (bus.SEL_I == CH_ID);

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
        r_count    <= '0;
        r_reload   <= '0;
        r_presc    <= '0;
        r_periodic <= 1'b0;
        r_busy     <= 1'b0;
        r_end      <= 1'b0;
        r_zero     <= 1'b0;
      end else begin
        r_end  <= 1'b0;
        r_zero <= 1'b0;
        if (w_start) begin
          // Start beats abort, a pending zero strobe and an expiry this edge.
          r_presc <= '0;
          if (bus.DAT_I != '0) begin
            r_count    <= bus.DAT_I;
            r_reload   <= bus.DAT_I;
            r_periodic <= bus.periodic_i;
            r_busy     <= 1'b1;
          end else begin
            r_count    <= '0;
            r_periodic <= 1'b0;
            r_busy     <= 1'b0;
            r_zero     <= 1'b1;
          end
        end else begin
          // r_zero implies the channel is idle, so no other branch sets r_end.
          if (r_zero) begin
            r_end <= 1'b1;
          end
          if (w_abort) begin
            r_count    <= '0;
            r_presc    <= '0;
            r_periodic <= 1'b0;
            r_busy     <= 1'b0;
          end else if (r_busy) begin
            if (r_presc == PRESC_LAST) begin
              r_presc <= '0;
              // busy guarantees r_count >= 1, so the count never wraps.
              if (r_count == WIDTH'(1)) begin
                r_end <= 1'b1;
                if (r_periodic) begin
                  r_count <= r_reload;
                end else begin
                  r_count <= '0;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_count <= r_count - WIDTH'(1);
              end
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
        end
      end
    end

    assign w_busy[g] = r_busy;
    assign w_end[g]  = r_end;
  end

endmodule

// File: tb/tb_state_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_state_timer_bank
// Directed bench for state_timer_bank. Three instances share one clock/reset:
//   u_a  CHANNELS=2, PRESCALE_DIV=1
//   u_b  CHANNELS=2, PRESCALE_DIV=4
//   u_c  CHANNELS=3, PRESCALE_DIV=1
// Inputs change and outputs are sampled 1 ns after each rising edge; the
// value seen after edge Ek is the registered state produced by Ek.
// -----------------------------------------------------------------------------
module tb_state_timer_bank;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  state_timer_bank_if #(.WIDTH(16), .CHANNELS(2)) ifa ();
  state_timer_bank_if #(.WIDTH(16), .CHANNELS(2)) ifb ();
  state_timer_bank_if #(.WIDTH(16), .CHANNELS(3)) ifc ();

  state_timer_bank #(.WIDTH(16), .CHANNELS(2), .PRESCALE_DIV(1)) u_a (
    .CLK_I(clk), .RST_N_I(rst_n), .bus(ifa.slave));
  state_timer_bank #(.WIDTH(16), .CHANNELS(2), .PRESCALE_DIV(4)) u_b (
    .CLK_I(clk), .RST_N_I(rst_n), .bus(ifb.slave));
  state_timer_bank #(.WIDTH(16), .CHANNELS(3), .PRESCALE_DIV(1)) u_c (
    .CLK_I(clk), .RST_N_I(rst_n), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input logic st, input logic ab, input logic per,
                       input logic sel, input logic [15:0] dat);
    ifa.start_strobe = st;
    ifa.abort_strobe = ab;
    ifa.periodic_i   = per;
    ifa.SEL_I        = sel;
    ifa.DAT_I        = dat;
  endtask

  task automatic b_set(input logic st, input logic ab, input logic per,
                       input logic sel, input logic [15:0] dat);
    ifb.start_strobe = st;
    ifb.abort_strobe = ab;
    ifb.periodic_i   = per;
    ifb.SEL_I        = sel;
    ifb.DAT_I        = dat;
  endtask

  task automatic c_set(input logic st, input logic ab, input logic per,
                       input logic [1:0] sel, input logic [15:0] dat);
    ifc.start_strobe = st;
    ifc.abort_strobe = ab;
    ifc.periodic_i   = per;
    ifc.SEL_I        = sel;
    ifc.DAT_I        = dat;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst_n = 1'b0;
    a_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    b_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    c_set(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);

    // Reset state
    #12;
    chk("rst_a", 32'({ifa.busy, ifa.end_strobe}), 32'h0);
    chk("rst_b", 32'({ifb.busy, ifb.end_strobe}), 32'h0);
    chk("rst_c", 32'({ifc.busy, ifc.end_strobe}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset mid-count: ch0 N=10, reset dropped between edges after E3
    a_set(1'b1, 1'b0, 1'b0, 1'b0, 16'd10);
    tick();
    a_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    chk("mid_busy_e0", 32'(ifa.busy[0]), 32'd1);
    for (int k = 1; k <= 3; k++) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_now", 32'({ifa.busy, ifa.end_strobe}), 32'h0);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk($sformatf("mid_after%0d", k), 32'({ifa.busy, ifa.end_strobe}), 32'h0);
    end

    // One-shot, no prescale: ch0 N=5, strobe at E5 only
    a_set(1'b1, 1'b0, 1'b0, 1'b0, 16'd5);
    tick();
    a_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      chk($sformatf("os_busy%0d", k), 32'(ifa.busy), 32'(k < 5));
      chk($sformatf("os_end%0d", k), 32'(ifa.end_strobe), 32'(k == 5));
    end

    // Prescaled one-shot: DIV=4, ch1 N=3, strobe at E12
    b_set(1'b1, 1'b0, 1'b0, 1'b1, 16'd3);
    tick();
    b_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) tick();
      chk($sformatf("ps_busy%0d", k), 32'(ifb.busy), (k < 12) ? 32'd2 : 32'd0);
      chk($sformatf("ps_end%0d", k), 32'(ifb.end_strobe), (k == 12) ? 32'd2 : 32'd0);
    end

    // Periodic then abort: ch1 N=2, strobes E2/E4/E6, abort at E7
    a_set(1'b1, 1'b0, 1'b1, 1'b1, 16'd2);
    tick();
    a_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int k = 1; k <= 11; k++) begin
      if (k == 7) a_set(1'b0, 1'b1, 1'b0, 1'b1, 16'd0);
      tick();
      a_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      chk($sformatf("per_busy%0d", k), 32'(ifa.busy[1]), 32'(k < 7));
      chk($sformatf("per_end%0d", k), 32'(ifa.end_strobe[1]), 32'(k == 2 || k == 4 || k == 6));
    end

    // Zero load: strobe at E1, never busy
    a_set(1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
    tick();
    a_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) tick();
      chk($sformatf("z_busy%0d", k), 32'(ifa.busy), 32'h0);
      chk($sformatf("z_end%0d", k), 32'(ifa.end_strobe), 32'(k == 1));
    end

    // Retrigger: N=8 at E0, N=3 at E5, single strobe at E8
    a_set(1'b1, 1'b0, 1'b0, 1'b0, 16'd8);
    tick();
    a_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) a_set(1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
      tick();
      a_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      chk($sformatf("rt_busy%0d", k), 32'(ifa.busy[0]), 32'(k < 8));
      chk($sformatf("rt_end%0d", k), 32'(ifa.end_strobe[0]), 32'(k == 8));
    end

    // Restart on own expiry edge: N=2 at E0, N=3 at E2 -> strobe E5 only
    a_set(1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    tick();
    a_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int k = 1; k <= 7; k++) begin
      if (k == 2) a_set(1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
      tick();
      a_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      chk($sformatf("ex_busy%0d", k), 32'(ifa.busy[0]), 32'(k < 5));
      chk($sformatf("ex_end%0d", k), 32'(ifa.end_strobe[0]), 32'(k == 5));
    end

    // Independence: ch0 N=4 at E0, ch1 N=2 at E2 -> both strobe at E4
    a_set(1'b1, 1'b0, 1'b0, 1'b0, 16'd4);
    tick();
    a_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) a_set(1'b1, 1'b0, 1'b0, 1'b1, 16'd2);
      tick();
      a_set(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
      chk($sformatf("ind_busy%0d", k), 32'(ifa.busy),
          32'({(k >= 2 && k < 4), (k < 4)}));
      chk($sformatf("ind_end%0d", k), 32'(ifa.end_strobe), (k == 4) ? 32'd3 : 32'd0);
    end

    // Out-of-range select on a 3-channel bank: start ignored
    c_set(1'b1, 1'b0, 1'b0, 2'd3, 16'd5);
    for (int k = 0; k <= 3; k++) begin
      tick();
      c_set(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
      chk($sformatf("oor_%0d", k), 32'({ifc.busy, ifc.end_strobe}), 32'h0);
    end

    // Start + abort together on ch2 (start wins), then abort with SEL=3 ignored
    c_set(1'b1, 1'b1, 1'b0, 2'd2, 16'd2);
    tick();
    c_set(1'b0, 1'b1, 1'b0, 2'd3, 16'd0);
    chk("sa_busy0", 32'(ifc.busy), 32'd4);
    tick();
    c_set(1'b0, 1'b0, 1'b0, 2'd0, 16'd0);
    chk("sa_busy1", 32'(ifc.busy), 32'd4);
    chk("sa_end1", 32'(ifc.end_strobe), 32'd0);
    tick();
    chk("sa_busy2", 32'(ifc.busy), 32'd0);
    chk("sa_end2", 32'(ifc.end_strobe), 32'd4);
    tick();
    chk("sa_end3", 32'(ifc.end_strobe), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
